// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser: raw push-button conditioning for the stack calculator.
// Per channel: 2-flop synchronizer, debounce FSM with saturating counter,
// debounced level output. Accepted presses are latched as pending and
// released one per clock on pulse_out, lowest channel index first.
//
// Optional feature macro: BTN_AUTOREPEAT_EN (adds held-button auto-repeat).
//
// Channel FSM:
//   state   | meaning
//   IDLE    | debounced level 0, input stable low
//   CHK_HI  | input went high, counting stable high samples
//   PRESSED | debounced level 1, input stable high
//   CHK_LO  | input went low, counting stable low samples

module btn_debounce_pulser #(
  parameter int                N_BTN           = 4,
  parameter int                CNT_W           = 16,
  parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = 16'd50000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter logic [23:0]       REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0]       REPEAT_PERIOD   = 24'd1000000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level_out,
  output logic [N_BTN-1:0] pulse_out,
  output logic [N_BTN-1:0] pending_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHK_HI  = 2'd1,
    PRESSED = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [N_BTN-1:0] accept_press;
  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] rpt_req;
  logic [N_BTN-1:0] cand;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] pending_nxt;

  // Two-flop synchronizer on every raw button line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: the counter never wraps past the threshold.
    assign cnt_inc = (cnt >= DEBOUNCE_CYCLES) ? cnt : cnt + CNT_W'(1);

    // Channel state and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Next-state logic; a change is accepted only after DEBOUNCE_CYCLES
    // consecutive matching samples, any contrary sample restarts.
    always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      accept_press[i] = 1'b0;
      case (state)
        IDLE: begin
          if (sync_b[i]) begin
            state_nxt = CHK_HI;
            cnt_nxt   = CNT_W'(1);
          end
        end
        CHK_HI: begin
          if (!sync_b[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt >= DEBOUNCE_CYCLES) begin
            state_nxt       = PRESSED;
            cnt_nxt         = '0;
            accept_press[i] = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        PRESSED: begin
          if (!sync_b[i]) begin
            state_nxt = CHK_LO;
            cnt_nxt   = CNT_W'(1);
          end
        end
        CHK_LO: begin
          if (sync_b[i]) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt >= DEBOUNCE_CYCLES) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Debounced level follows the accepted side of the FSM.
    assign level_nxt[i] = (state_nxt == PRESSED) || (state_nxt == CHK_LO);

`ifdef BTN_AUTOREPEAT_EN
    logic [23:0] rpt_cnt;
    logic [23:0] rpt_cnt_nxt;
    logic [23:0] rpt_inc;
    logic        rpt_phase;
    logic        rpt_phase_nxt;

    assign rpt_inc = rpt_cnt + 24'd1;

    // Repeat counter and delay/period phase; both cleared outside PRESSED.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else begin
        rpt_cnt   <= rpt_cnt_nxt;
        rpt_phase <= rpt_phase_nxt;
      end
    end

    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD while held.
    always_comb begin
      rpt_cnt_nxt   = '0;
      rpt_phase_nxt = 1'b0;
      rpt_req[i]    = 1'b0;
      if (state == PRESSED && state_nxt == PRESSED) begin
        if (rpt_inc >= (rpt_phase ? REPEAT_PERIOD : REPEAT_DELAY)) begin
          rpt_req[i]    = 1'b1;
          rpt_phase_nxt = 1'b1;
        end else begin
          rpt_cnt_nxt   = rpt_inc;
          rpt_phase_nxt = rpt_phase;
        end
      end
    end
`else
    assign rpt_req[i] = 1'b0;
`endif
  end

  // Fixed-priority grant: lowest-index candidate wins, the rest stay pending.
  always_comb begin
    cand = pending | accept_press | rpt_req;
    grant = '0;
    for (int j = N_BTN - 1; j >= 0; j--) begin
      if (cand[j]) grant = N_BTN'(1) << j;
    end
    pending_nxt = cand & ~grant;
  end

  // Registered outputs: level, one-cycle pulse and post-grant pending vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_out <= '0;
      pulse_out <= '0;
      pending   <= '0;
    end else begin
      level_out <= level_nxt;
      pulse_out <= grant;
      pending   <= pending_nxt;
    end
  end

  assign pending_out = pending;

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// Directed bench for btn_debounce_pulser with DEBOUNCE_CYCLES=4, N_BTN=4.
// Expected output vectors are queued per cycle as stimulus is applied and
// compared on the falling edge of the cycle they refer to. Cycles without a
// queued entry must show no pulse.

module tb_btn_debounce_pulser;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] level_out;
  logic [3:0] pulse_out;
  logic [3:0] pending_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] pending;
  } exp_t;

  exp_t exp_q[$];

  btn_debounce_pulser #(
    .N_BTN          (4),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .level_out  (level_out),
    .pulse_out  (pulse_out),
    .pending_out(pending_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] pe);
    exp_t e;
    e.cyc = c; e.level = l; e.pulse = p; e.pending = pe;
    exp_q.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    chk("onehot", {3'b000, $onehot0(pulse_out)}, 4'b0001);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("level", level_out, e.level);
      chk("pulse", pulse_out, e.pulse);
      chk("pending", pending_out, e.pending);
    end else begin
      chk("pulse_idle", pulse_out, 4'b0000);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    btn_in = 4'b0000;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    chk("rst_level", level_out, 4'b0000);
    chk("rst_pulse", pulse_out, 4'b0000);
    chk("rst_pending", pending_out, 4'b0000);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'b0000;

    // Clean press on channel 0 from cycle 10.
    do_reset();
    expect_at(15, 4'b0000, 4'b0000, 4'b0000);
    expect_at(16, 4'b0001, 4'b0001, 4'b0000);
    expect_at(17, 4'b0001, 4'b0000, 4'b0000);
    expect_at(25, 4'b0001, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b0001;
    run_cycles(16);

    // Bounce 1,0,1,0 on channel 1.
    do_reset();
    expect_at(14, 4'b0000, 4'b0000, 4'b0000);
    expect_at(20, 4'b0000, 4'b0000, 4'b0000);
    expect_at(25, 4'b0000, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b0010; run_cycles(1);
    btn_in = 4'b0000; run_cycles(1);
    btn_in = 4'b0010; run_cycles(1);
    btn_in = 4'b0000; run_cycles(13);

    // Threshold: 4 high samples on ch1 rejected, 5 on ch2 accepted.
    do_reset();
    expect_at(15, 4'b0000, 4'b0000, 4'b0000);
    expect_at(16, 4'b0100, 4'b0100, 4'b0000);
    expect_at(20, 4'b0100, 4'b0000, 4'b0000);
    expect_at(21, 4'b0000, 4'b0000, 4'b0000);
    expect_at(24, 4'b0000, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b0110; run_cycles(4);
    btn_in = 4'b0100; run_cycles(1);
    btn_in = 4'b0000; run_cycles(10);

    // Simultaneous press on channels 0 and 1.
    do_reset();
    expect_at(16, 4'b0011, 4'b0001, 4'b0010);
    expect_at(17, 4'b0011, 4'b0010, 4'b0000);
    expect_at(18, 4'b0011, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b0011;
    run_cycles(9);

    // Hold channel 2 for 20 cycles then release: level falls 6 later, no pulse.
    do_reset();
    expect_at(16, 4'b0100, 4'b0100, 4'b0000);
    expect_at(35, 4'b0100, 4'b0000, 4'b0000);
    expect_at(36, 4'b0000, 4'b0000, 4'b0000);
    expect_at(40, 4'b0000, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b0100; run_cycles(20);
    btn_in = 4'b0000; run_cycles(11);

    // All four at once: priority order drains one per cycle.
    do_reset();
    expect_at(16, 4'b1111, 4'b0001, 4'b1110);
    expect_at(17, 4'b1111, 4'b0010, 4'b1100);
    expect_at(18, 4'b1111, 4'b0100, 4'b1000);
    expect_at(19, 4'b1111, 4'b1000, 4'b0000);
    expect_at(20, 4'b1111, 4'b0000, 4'b0000);
    run_cycles(9);
    btn_in = 4'b1111;
    run_cycles(11);

    // Async reset with pending bits, then re-press of channel 3 after release.
    do_reset();
    expect_at(16, 4'b1111, 4'b0001, 4'b1110);
    run_cycles(9);
    btn_in = 4'b1111;
    run_cycles(7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level", level_out, 4'b0000);
    chk("async_rst_pulse", pulse_out, 4'b0000);
    chk("async_rst_pending", pending_out, 4'b0000);
    btn_in = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_pulse", pulse_out, 4'b0000);
    chk("rst_held_pending", pending_out, 4'b0000);
    rst = 1'b0;
    cyc = 0;
    expect_at(6, 4'b0000, 4'b0000, 4'b0000);
    expect_at(7, 4'b1000, 4'b1000, 4'b0000);
    expect_at(8, 4'b1000, 4'b0000, 4'b0000);
    run_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
